// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings for the TX and RX machines,
// default bit timing and frame shape.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 217;  // 25 MHz / 115200 baud
  localparam int DATA_BITS            = 8;
  localparam int STOP_BITS            = 1;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START_BIT,
    TX_DATA_BITS,
    TX_STOP_BIT
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START_BIT,
    RX_DATA_BITS,
    RX_STOP_BIT,
    RX_CLEANUP
  } rx_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake and line signals between fabric logic and the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic                 tx_dv;
  logic [DATA_BITS-1:0] tx_byte;
  logic                 tx_ready;
  logic                 tx_active;
  logic                 tx_serial;
  logic                 tx_done;

  modport master (
    output tx_dv, tx_byte,
    input  tx_ready, tx_active, tx_serial, tx_done
  );

  modport slave (
    input  tx_dv, tx_byte,
    output tx_ready, tx_active, tx_serial, tx_done
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter: strobes tc on the last cycle of every CLKS_PER_BIT window.
// Shared between the UART transmitter and receiver.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tc
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || restart || tc) cnt <= '0;
    else                      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1, with a one-entry holding register so a second byte
// can be queued during a frame and sent with no idle gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic     i_Clock,
  input  logic     i_Reset,
  uart_tx_if.slave tx
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  tx_state_t            state;
  logic                 ready;
  logic                 active;
  logic                 serial;
  logic                 done;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] hold;
  logic                 tc;
  logic                 accept;
  logic                 stop_end;
  logic                 load_direct;
  logic                 load_hold;

  assign accept      = tx.tx_dv && ready;
  assign stop_end    = (state == TX_STOP_BIT) && tc;
  // A byte offered while the line is free (idle or stop-bit end) bypasses holding.
  assign load_direct = accept && ((state == TX_IDLE) || stop_end);
  assign load_hold   = accept && !load_direct;

  assign tx.tx_ready  = ready;
  assign tx.tx_active = active;
  assign tx.tx_serial = serial;
  assign tx.tx_done   = done;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) bit_timer (
    .clk     (i_Clock),
    .rst     (i_Reset),
    .restart (state == TX_IDLE),
    .tc      (tc)
  );

  always_ff @(posedge i_Clock) begin
    if (load_direct)            shift <= tx.tx_byte;
    else if (stop_end && !ready) shift <= hold;
    if (load_hold)              hold  <= tx.tx_byte;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state  <= TX_IDLE;
      ready  <= 1'b1;
      active <= 1'b0;
      serial <= 1'b1;
      done   <= 1'b0;
      idx    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        TX_IDLE: begin
          serial <= 1'b1;
          if (accept) begin
            state  <= TX_START_BIT;
            serial <= 1'b0;
            active <= 1'b1;
          end
        end
        TX_START_BIT: begin
          if (tc) begin
            state  <= TX_DATA_BITS;
            idx    <= '0;
            serial <= shift[0];
          end
        end
        TX_DATA_BITS: begin
          if (tc) begin
            if (idx == LAST_IDX) begin
              state  <= TX_STOP_BIT;
              serial <= 1'b1;
            end else begin
              idx    <= idx + IDX_W'(1);
              serial <= shift[idx + IDX_W'(1)];
            end
          end
        end
        TX_STOP_BIT: begin
          if (tc) begin
            done <= 1'b1;
            if (!ready || accept) begin
              // Next frame starts on the very next cycle, keeping Active high.
              ready  <= 1'b1;
              state  <= TX_START_BIT;
              serial <= 1'b0;
            end else begin
              state  <= TX_IDLE;
              active <= 1'b0;
            end
          end
        end
        default: state <= TX_IDLE;
      endcase
      if (load_hold) ready <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-level reference model and a line decoder checked
// against two instances (4 and 217 clocks per bit), plus directed literal checks.
module tb_uart_tx;

  localparam int C0 = 4;
  localparam int C1 = 217;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_if if0 ();
  uart_tx_if if1 ();

  uart_tx #(.CLKS_PER_BIT(C0)) dut0 (.i_Clock(clk), .i_Reset(rst), .tx(if0));
  uart_tx #(.CLKS_PER_BIT(C1)) dut1 (.i_Clock(clk), .i_Reset(rst), .tx(if1));

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------- reference model: one frame = 10 bits of cpb cycles
  int         cpb [2] = '{C0, C1};
  bit         m_busy [2];
  bit         m_hold_full [2];
  bit         m_done [2];
  logic [7:0] m_cur [2];
  logic [7:0] m_hold [2];
  int         m_t [2];

  task automatic step(int i, logic dv, logic [7:0] b);
    bit acc;
    if (rst) begin
      m_busy[i] = 0; m_hold_full[i] = 0; m_done[i] = 0; m_t[i] = 0;
      return;
    end
    acc = dv && !m_hold_full[i];
    m_done[i] = 0;
    if (m_busy[i]) begin
      m_t[i]++;
      if (m_t[i] == 10 * cpb[i]) begin
        m_done[i] = 1;
        if (m_hold_full[i]) begin
          m_cur[i] = m_hold[i]; m_hold_full[i] = 0; m_t[i] = 0;
        end else if (acc) begin
          m_cur[i] = b; m_t[i] = 0;
        end else begin
          m_busy[i] = 0;
        end
      end else if (acc) begin
        m_hold[i] = b; m_hold_full[i] = 1;
      end
    end else if (acc) begin
      m_cur[i] = b; m_busy[i] = 1; m_t[i] = 0;
    end
  endtask

  function automatic logic exp_serial(int i);
    int k;
    if (!m_busy[i]) return 1'b1;
    k = m_t[i] / cpb[i];
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_cur[i][k-1];
  endfunction

  function automatic logic [3:0] model_out(int i);
    return {exp_serial(i), m_busy[i], !m_hold_full[i], m_done[i]};
  endfunction

  function automatic logic [3:0] dut_out(int i);
    if (i == 0) return {if0.tx_serial, if0.tx_active, if0.tx_ready, if0.tx_done};
    return {if1.tx_serial, if1.tx_active, if1.tx_ready, if1.tx_done};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    step(0, if0.tx_dv, if0.tx_byte);
    step(1, if1.tx_dv, if1.tx_byte);
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("model_dut0 {ser,act,rdy,done}", 32'(dut_out(0)), 32'(model_out(0)));
      chk("model_dut1 {ser,act,rdy,done}", 32'(dut_out(1)), 32'(model_out(1)));
    end
  end

  // ---------------- line decoder (receiver stand-in) and Done monitor
  logic [7:0] rxq0 [$];
  logic [7:0] rxq1 [$];
  bit         d_busy [2];
  int         d_cnt [2];
  logic [7:0] d_byte [2];
  int         ferr = 0;
  int         done_cnt0 = 0;
  int         done_cnt1 = 0;

  initial forever begin
    @(negedge clk);
    if (if0.tx_done === 1'b1) done_cnt0++;
    if (if1.tx_done === 1'b1) done_cnt1++;
    for (int i = 0; i < 2; i++) begin
      logic line;
      int   k;
      line = (i == 0) ? if0.tx_serial : if1.tx_serial;
      if (rst) begin
        d_busy[i] = 0;
      end else begin
        if (!d_busy[i] && line === 1'b0) begin
          d_busy[i] = 1; d_cnt[i] = 0;
        end
        if (d_busy[i]) begin
          if (d_cnt[i] % cpb[i] == cpb[i] / 2) begin
            k = d_cnt[i] / cpb[i];
            if (k >= 1 && k <= 8) d_byte[i][k-1] = line;
            else if (k == 9) begin
              if (line !== 1'b1) ferr++;
              else if (i == 0) rxq0.push_back(d_byte[i]);
              else rxq1.push_back(d_byte[i]);
              d_busy[i] = 0;
            end
          end
          d_cnt[i]++;
        end
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(int i, logic dv, logic [7:0] b);
    if (i == 0) begin if0.tx_dv = dv; if0.tx_byte = b; end
    else        begin if1.tx_dv = dv; if1.tx_byte = b; end
  endtask

  task automatic send(int i, logic [7:0] b);
    set_in(i, 1'b1, b);
    tick();
    set_in(i, 1'b0, 8'h00);
  endtask

  task automatic wait_ready(int i, int budget);
    int n = 0;
    while (dut_out(i)[1] !== 1'b1 && n < budget) begin tick(); n++; end
    if (n >= budget) chk("wait_ready timeout", 0, 1);
  endtask

  task automatic wait_idle(int i, int budget);
    int n = 0;
    while (!(dut_out(i)[2] === 1'b0 && dut_out(i)[1] === 1'b1) && n < budget) begin
      tick(); n++;
    end
    if (n >= budget) chk("wait_idle timeout", 0, 1);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [9:0] a5_bits = 10'b1101001010;  // [k] = line level of bit k
  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];
  int         acc_cyc;
  int         dsave;

  initial begin
    set_in(0, 1'b0, 8'h00);
    set_in(1, 1'b0, 8'h00);
    rst = 1'b1;
    tick(); tick();
    chk_en = 1'b1;
    chk("reset serial", 32'(if0.tx_serial), 1);
    chk("reset active", 32'(if0.tx_active), 0);
    chk("reset ready",  32'(if0.tx_ready),  1);
    chk("reset done",   32'(if0.tx_done),   0);
    rst = 1'b0;
    tick();

    // single byte 0xA5
    send(0, 8'hA5); acc_cyc = cyc; exp0.push_back(8'hA5);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("a5 bit%0d", k), 32'(if0.tx_serial), 32'(a5_bits[k]));
      chk("a5 ready", 32'(if0.tx_ready), 1);
      repeat (C0) tick();
    end
    chk("a5 done edge", 32'(cyc - acc_cyc), 40);
    chk("a5 done", 32'(if0.tx_done), 1);
    chk("a5 active drop", 32'(if0.tx_active), 0);
    tick();
    chk("a5 done width", 32'(if0.tx_done), 0);
    wait_idle(0, 100);

    // back-to-back 0x00 then 0xFF
    send(0, 8'h00); exp0.push_back(8'h00);
    repeat (4) tick();
    send(0, 8'hFF); exp0.push_back(8'hFF);
    chk("b2b ready low", 32'(if0.tx_ready), 0);
    repeat (34) tick();
    chk("b2b ready before handoff", 32'(if0.tx_ready), 0);
    tick();
    chk("b2b handoff ready", 32'(if0.tx_ready), 1);
    chk("b2b done1", 32'(if0.tx_done), 1);
    chk("b2b no gap serial", 32'(if0.tx_serial), 0);
    chk("b2b active", 32'(if0.tx_active), 1);
    repeat (40) tick();
    chk("b2b done2", 32'(if0.tx_done), 1);
    chk("b2b active end", 32'(if0.tx_active), 0);
    wait_idle(0, 100);

    // overflow: 0x3C offered while holding is full
    send(0, 8'h11); exp0.push_back(8'h11);
    send(0, 8'h22); exp0.push_back(8'h22);
    set_in(0, 1'b1, 8'h3C);
    repeat (10) begin
      chk("ovf ready", 32'(if0.tx_ready), 0);
      tick();
    end
    set_in(0, 1'b0, 8'h00);
    wait_idle(0, 200);

    // accept exactly on the stop-bit terminal edge
    send(0, 8'h5A); exp0.push_back(8'h5A);
    repeat (39) tick();
    send(0, 8'h81); exp0.push_back(8'h81);
    chk("stopedge done", 32'(if0.tx_done), 1);
    chk("stopedge serial", 32'(if0.tx_serial), 0);
    chk("stopedge active", 32'(if0.tx_active), 1);
    chk("stopedge ready", 32'(if0.tx_ready), 1);
    wait_idle(0, 100);

    // reset during data bit 3 of 0x55
    send(0, 8'h55);
    repeat (16) tick();
    dsave = done_cnt0;
    rst = 1'b1;
    tick();
    chk("midrst serial", 32'(if0.tx_serial), 1);
    chk("midrst active", 32'(if0.tx_active), 0);
    chk("midrst ready",  32'(if0.tx_ready),  1);
    rst = 1'b0;
    repeat (50) tick();
    chk("midrst no done", 32'(done_cnt0), 32'(dsave));
    send(0, 8'h12); exp0.push_back(8'h12);
    wait_idle(0, 100);

    chk("dut0 rx count", 32'(rxq0.size()), 32'(exp0.size()));
    while (rxq0.size() > 0 && exp0.size() > 0)
      chk("dut0 rx byte", 32'(rxq0.pop_front()), 32'(exp0.pop_front()));

    // loopback at 217 clocks per bit, back-to-back
    dsave = done_cnt1;
    send(1, 8'h00); exp1.push_back(8'h00);
    send(1, 8'hFF); exp1.push_back(8'hFF);
    wait_ready(1, 3000);
    send(1, 8'h3C); exp1.push_back(8'h3C);
    wait_ready(1, 3000);
    send(1, 8'hC3); exp1.push_back(8'hC3);
    wait_idle(1, 6000);
    chk("loop done count", 32'(done_cnt1 - dsave), 4);
    chk("loop rx count", 32'(rxq1.size()), 4);
    while (rxq1.size() > 0 && exp1.size() > 0)
      chk("loop rx byte", 32'(rxq1.pop_front()), 32'(exp1.pop_front()));
    chk("framing errors", 32'(ferr), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
